segment_sampler: RTL and testbench

Draws one signed 8-bit value from a single segment produced by selectSegment: type, from, to. The segment is the output of the segment-choice stage that feeds the variable-update step of the MCMC solver.
- UNIFORM segments use bounded-mask rejection sampling.
- EXPDOWN and EXPUP segments use a bit-per-cycle truncated geometric walk (p = 1/2), matching the segment weight 2·(1−2^−n).
- It is a multi-cycle FSM with a start/busy/valid handshake and its own 8-bit Galois LFSR.

---
 rtl/segment_pkg.sv | 50 +++++
 rtl/segment_sampler_if.sv | 40 ++++
 rtl/segment_sampler_lfsr8.sv | 34 +++
 rtl/segment_sampler.sv | 182 ++++++++++++++++++
 tb/tb_segment_sampler.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/segment_pkg.sv
// segment_pkg
// Shared constants and types for the segment sampler and its neighbours in
// the MCMC variable-update path.
//   - Segment type codes (EXPDOWN, EXPUP, UNIFORM; code 0 is invalid).
//   - Variable range limits MINIMUM_VARIABLE / MAXIMUM_VARIABLE.
//   - LFSR taps and LFSR reset value.
//   - Sampler FSM state enum.
//   - Helpers for span and rejection-mask computation.
package segment_pkg;

  localparam logic [1:0] SEG_INVALID = 2'd0;
  localparam logic [1:0] EXPDOWN     = 2'd1;
  localparam logic [1:0] EXPUP       = 2'd2;
  localparam logic [1:0] UNIFORM     = 2'd3;

  localparam logic signed [7:0] MINIMUM_VARIABLE = 8'sh80;  // -128
  localparam logic signed [7:0] MAXIMUM_VARIABLE = 8'sh7F;  //  127

  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  // Number of rejected uniform draws after which the sampler gives up
  // rejecting (only used when the retry limit is compiled in).
  localparam logic [3:0] RETRY_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UNIF = 2'd1,
    WALK = 2'd2
  } sampler_state_t;

  // Distance to - from as an unsigned 9-bit value. Both bounds are sign
  // extended first, so any legal segment (from <= to) yields 0..255.
  function automatic logic [8:0] segment_span(input logic signed [7:0] from,
                                              input logic signed [7:0] to);
    return {to[7], to} - {from[7], from};
  endfunction

  // Smallest 2^k-1 that is >= span: every bit at or below the highest set
  // bit of span is set. span 0 gives mask 0.
  function automatic logic [7:0] span_mask(input logic [8:0] span);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if ((span >> i) != 9'd0) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/segment_sampler_if.sv
// segment_sampler_if
// Request/result bundle between a segment requester (master) and the
// sampler (slave).
//   in_seed_load / in_seed   : synchronous LFSR reload, wins over in_start.
//   in_start                 : request strobe with in_segment_type/from/to.
//   out_busy                 : sampler is drawing.
//   out_valid                : one-cycle result pulse with out_value/out_error.
//
// Handshake: a request is accepted on any rising edge where in_start=1,
// in_seed_load=0 and out_busy=0; the segment fields are captured on that
// edge only and may change afterwards. out_busy is high from the cycle
// after accept until the result cycle, in which out_busy=0 and
// out_valid=1, so a new request may be presented in the result cycle.
// in_start while out_busy=1 is ignored, not queued. out_error and
// out_value are meaningful only while out_valid=1; out_value is held
// between results.
interface segment_sampler_if;
  logic              in_seed_load;
  logic [7:0]        in_seed;
  logic              in_start;
  logic [1:0]        in_segment_type;
  logic signed [7:0] in_segment_from;
  logic signed [7:0] in_segment_to;
  logic              out_busy;
  logic              out_valid;
  logic signed [7:0] out_value;
  logic              out_error;

  modport master (
    output in_seed_load, in_seed, in_start,
           in_segment_type, in_segment_from, in_segment_to,
    input  out_busy, out_valid, out_value, out_error
  );

  modport slave (
    input  in_seed_load, in_seed, in_start,
           in_segment_type, in_segment_from, in_segment_to,
    output out_busy, out_valid, out_value, out_error
  );
endinterface

// File: rtl/segment_sampler_lfsr8.sv
// lfsr8
// 8-bit Galois LFSR (taps 8'hB8, right shift), reusable by other random
// choice blocks.
//   in_clock    : clock, rising edge.
//   in_reset_n  : asynchronous active-low reset, state -> 8'h01.
//   in_load     : load in_seed (8'h00 is replaced by 8'h01); wins over step.
//   in_seed     : seed value.
//   in_step     : advance one step.
//   out_state   : current state, never zero.
module lfsr8 import segment_pkg::*; (
  input  logic       in_clock,
  input  logic       in_reset_n,
  input  logic       in_load,
  input  logic [7:0] in_seed,
  input  logic       in_step,
  output logic [7:0] out_state
);

  logic [7:0] state_q;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= LFSR_RESET;
    end else if (in_load) begin
      // All-zero is the lock-up state of the LFSR, so it is never loaded.
      state_q <= (in_seed == 8'h00) ? 8'h01 : in_seed;
    end else if (in_step) begin
      state_q <= state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    end
  end

  assign out_state = state_q;

endmodule

// File: rtl/segment_sampler.sv
// segment_sampler
// Draws one signed 8-bit value from a segment {type, from, to}.
//   UNIFORM         : bounded-mask rejection sampling, one draw per cycle.
//   EXPDOWN / EXPUP : truncated geometric walk, one LFSR bit per cycle,
//                     moving away from 'from' (EXPDOWN) or 'to' (EXPUP).
// Ports:
//   in_clock, in_reset_n : clock and asynchronous active-low reset.
//   sampler              : segment_sampler_if.slave (request/result bundle).
//   out_state            : current FSM state, for debug and checkers.
// Optional feature: define SEGMENT_SAMPLER_RETRY_LIMIT_EN to bound uniform
// rejection at 16 draws; on the 16th rejection the result is from+(r>>1).
module segment_sampler import segment_pkg::*; (
  input  logic                     in_clock,
  input  logic                     in_reset_n,
  segment_sampler_if.slave         sampler,
  output sampler_state_t           out_state
);

  sampler_state_t    state_q, state_d;
  logic signed [7:0] from_q, from_d;
  logic signed [7:0] to_q, to_d;
  logic [8:0]        span_q, span_d;
  logic [7:0]        mask_q, mask_d;
  logic signed [7:0] acc_q, acc_d;
  logic              walk_up_q, walk_up_d;
  logic signed [7:0] value_q, value_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
  logic [3:0]        retry_q, retry_d;
`endif

  logic [7:0]        lfsr;
  logic              draw;
  logic              accept;
  logic [8:0]        req_span;
  logic              req_bad;
  logic [7:0]        unif_r;
  logic              unif_hit;
  logic signed [7:0] walk_end;

  // The LFSR only moves on draw cycles, so an idle sampler (and an error
  // request) leaves the sequence untouched.
  assign draw = (state_q != IDLE);

  lfsr8 u_lfsr (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_load    (sampler.in_seed_load),
    .in_seed    (sampler.in_seed),
    .in_step    (draw),
    .out_state  (lfsr)
  );

  assign accept   = sampler.in_start && !sampler.in_seed_load && (state_q == IDLE);
  assign req_span = segment_span(sampler.in_segment_from, sampler.in_segment_to);
  assign req_bad  = (sampler.in_segment_type == SEG_INVALID) ||
                    (sampler.in_segment_from > sampler.in_segment_to);

  assign unif_r   = lfsr & mask_q;
  assign unif_hit = ({1'b0, unif_r} <= span_q);

  // EXPDOWN walks up from 'from' and stops at 'to'; EXPUP walks down from
  // 'to' and stops at 'from'.
  assign walk_end = walk_up_q ? to_q : from_q;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q   <= IDLE;
      from_q    <= '0;
      to_q      <= '0;
      span_q    <= '0;
      mask_q    <= '0;
      acc_q     <= '0;
      walk_up_q <= 1'b0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      from_q    <= from_d;
      to_q      <= to_d;
      span_q    <= span_d;
      mask_q    <= mask_d;
      acc_q     <= acc_d;
      walk_up_q <= walk_up_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    from_d    = from_q;
    to_d      = to_q;
    span_d    = span_q;
    mask_d    = mask_q;
    acc_d     = acc_q;
    walk_up_d = walk_up_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          from_d    = sampler.in_segment_from;
          to_d      = sampler.in_segment_to;
          span_d    = req_span;
          mask_d    = span_mask(req_span);
          walk_up_d = (sampler.in_segment_type == EXPDOWN);
          acc_d     = (sampler.in_segment_type == EXPUP) ? sampler.in_segment_to
                                                         : sampler.in_segment_from;
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
          retry_d   = '0;
`endif
          if (req_bad) begin
            // Invalid requests answer next cycle without ever going busy.
            valid_d = 1'b1;
            error_d = 1'b1;
            value_d = sampler.in_segment_from;
          end else if (sampler.in_segment_type == UNIFORM) begin
            state_d = UNIF;
          end else begin
            state_d = WALK;
          end
        end
      end

      UNIF: begin
        if (unif_hit) begin
          // from + r stays inside [from, to], so 8-bit arithmetic cannot wrap.
          value_d = from_q + unif_r;
          valid_d = 1'b1;
          state_d = IDLE;
        end
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
        else if (retry_q == RETRY_LAST) begin
          // A rejected r is at most mask, and mask>>1 <= span, so halving
          // the rejected draw always lands inside the segment.
          value_d = from_q + {1'b0, unif_r[7:1]};
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          retry_d = retry_q + 4'd1;
        end
`endif
      end

      WALK: begin
        if (lfsr[0] && (acc_q != walk_end)) begin
          acc_d = walk_up_q ? (acc_q + 8'sd1) : (acc_q - 8'sd1);
        end else begin
          value_d = acc_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sampler.out_busy  = (state_q != IDLE);
  assign sampler.out_valid = valid_q;
  assign sampler.out_value = value_q;
  assign sampler.out_error = error_q;
  assign out_state         = state_q;

endmodule

// File: tb/tb_segment_sampler.sv
// tb_segment_sampler
// Self-checking bench for segment_sampler: directed cases with hand-worked
// values, a reset-mid-walk case, a held-seed rejection case and a randomized
// request stream compared every cycle against a transaction-level model.
module tb_segment_sampler;
  import segment_pkg::*;

  logic           in_clock = 1'b0;
  logic           in_reset_n = 1'b0;
  sampler_state_t out_state;

  segment_sampler_if sif ();

  segment_sampler dut (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .sampler    (sif),
    .out_state  (out_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 in_clock = ~in_clock;

  int cyc = 0;
  always @(posedge in_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int value;
    bit err;
    int accept_cyc;
    int valid_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_lfsr = 8'h01;
  bit         model_on = 1'b0;
  int         held_value = 0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
  endfunction

  // Predicts result, error flag and latency (cycles from accept to
  // out_valid) of one request, consuming the model's LFSR sequence.
  function automatic void predict(input int t, input int f, input int hi,
                                  output int val, output int lat, output bit err);
    int  span, mask, r, draws, n;
    bit  done;
    err = 1'b0;
    val = f;
    lat = 1;
    if (t == 0 || f > hi) begin
      err = 1'b1;
      return;
    end
    span  = hi - f;
    draws = 0;
    done  = 1'b0;
    n     = 0;
    if (t == 3) begin
      mask = 0;
      while (mask < span) mask = mask * 2 + 1;
      while (!done) begin
        draws++;
        r = int'(model_lfsr) & mask;
        model_lfsr = lfsr_next(model_lfsr);
        if (r <= span) begin
          val  = f + r;
          done = 1'b1;
        end
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
        else if (draws == 16) begin
          val  = f + r / 2;
          done = 1'b1;
        end
`endif
      end
    end else begin
      // Number of consecutive 1 bits, capped at the span.
      while (!done) begin
        draws++;
        r = int'(model_lfsr[0]);
        model_lfsr = lfsr_next(model_lfsr);
        if (r == 1 && n < span) n++;
        else done = 1'b1;
      end
      val = (t == 1) ? f + n : hi - n;
    end
    lat = draws + 1;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge in_clock) begin
    exp_t e;
    bit   ev, eb;
    if (model_on) begin
      ev = 1'b0;
      eb = 1'b0;
      if (exp_q.size() > 0) begin
        e  = exp_q[0];
        ev = (cyc == e.valid_cyc);
        eb = (cyc > e.accept_cyc) && (cyc < e.valid_cyc);
      end
      chk("out_valid", int'(sif.out_valid), int'(ev));
      chk("out_busy", int'(sif.out_busy), int'(eb));
      if (ev) begin
        chk("out_value", int'(sif.out_value), e.value);
        chk("out_error", int'(sif.out_error), int'(e.err));
        held_value = e.value;
        void'(exp_q.pop_front());
      end else begin
        chk("out_value_held", int'(sif.out_value), held_value);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge in_clock);
    #1;
  endtask

  task automatic load_seed(input int s);
    sif.in_seed      = s[7:0];
    sif.in_seed_load = 1'b1;
    tick();
    sif.in_seed_load = 1'b0;
    model_lfsr = (s[7:0] == 8'h00) ? 8'h01 : s[7:0];
  endtask

  // Presents a request for one cycle; returns the model's prediction.
  // Called at posedge+1 with the sampler able to accept.
  task automatic issue(input int t, input int f, input int hi,
                       output int val, output int lat);
    exp_t e;
    bit   err;
    predict(t, f, hi, val, lat, err);
    e.value      = val;
    e.err        = err;
    e.accept_cyc = cyc;
    e.valid_cyc  = cyc + lat;
    exp_q.push_back(e);
    sif.in_segment_type = t[1:0];
    sif.in_segment_from = f[7:0];
    sif.in_segment_to   = hi[7:0];
    sif.in_start        = 1'b1;
    tick();
    sif.in_start = 1'b0;
  endtask

  // Moves to the result cycle; without b2b also steps past it.
  task automatic wait_done(input int lat, input bit b2b);
    repeat (lat - 1) tick();
    if (!b2b) tick();
  endtask

  task automatic directed(input string name, input int t, input int f, input int hi,
                          input int pin_val, input int pin_lat);
    int v, l;
    issue(t, f, hi, v, l);
    chk({name, "_model_value"}, v, pin_val);
    chk({name, "_model_latency"}, l, pin_lat);
    wait_done(l, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int  v, l, t, f, hi, tmp, c0;
    bit  b2b, prev_b2b, bad;

    sif.in_seed_load    = 1'b0;
    sif.in_seed         = 8'h00;
    sif.in_start        = 1'b0;
    sif.in_segment_type = 2'd0;
    sif.in_segment_from = 8'sd0;
    sif.in_segment_to   = 8'sd0;

    repeat (2) @(posedge in_clock);
    #1;
    chk("reset_busy", int'(sif.out_busy), 0);
    chk("reset_valid", int'(sif.out_valid), 0);
    chk("reset_value", int'(sif.out_value), 0);
    chk("reset_error", int'(sif.out_error), 0);
    chk("reset_state", int'(out_state), int'(IDLE));
    in_reset_n = 1'b1;
    tick();
    model_on = 1'b1;

    // Directed cases with hand-worked expectations.
    load_seed(8'h01);
    directed("unif_10_13", 3, 10, 13, 11, 2);
    load_seed(8'h07);
    directed("unif_0_4", 3, 0, 4, 3, 3);
    load_seed(8'h01);
    directed("expdown_0_127", 1, 0, 127, 1, 3);
    load_seed(8'h01);
    directed("expup_m128_5", 2, -128, 5, 4, 3);
    load_seed(8'h01);
    directed("err_type0", 0, 5, 9, 5, 1);
    directed("err_from_gt_to", 3, 5, -3, 5, 1);
    directed("unif_after_err", 3, 10, 13, 11, 2);
    load_seed(8'h00);
    directed("unif_full_range", 3, -128, 127, -127, 2);
    directed("expdown_single", 1, 127, 127, 127, 2);
    directed("expup_single", 2, -128, -128, -128, 2);

    // Back-to-back: second request presented in the first one's result cycle.
    load_seed(8'h01);
    issue(3, 10, 13, v, l);
    wait_done(l, 1'b1);
    issue(2, -128, 5, v, l);
    wait_done(l, 1'b0);

    // Held seed reload while busy: every uniform draw sees 8'h07 and rejects.
    load_seed(8'h07);
    model_on = 1'b0;
    sif.in_segment_type = UNIFORM;
    sif.in_segment_from = 8'sd0;
    sif.in_segment_to   = 8'sd4;
    sif.in_start        = 1'b1;
    tick();
    sif.in_start     = 1'b0;
    sif.in_seed      = 8'h07;
    sif.in_seed_load = 1'b1;
    bad = 1'b0;
`ifdef SEGMENT_SAMPLER_RETRY_LIMIT_EN
    for (int k = 1; k <= 16; k++) begin
      if (!sif.out_busy || sif.out_valid) bad = 1'b1;
      tick();
    end
    sif.in_seed_load = 1'b0;
    chk("retry_busy_through_16", int'(bad), 0);
    chk("retry_valid_cycle17", int'(sif.out_valid), 1);
    chk("retry_value", int'(sif.out_value), 3);
    chk("retry_error", int'(sif.out_error), 0);
    chk("retry_busy_low", int'(sif.out_busy), 0);
`else
    for (int k = 1; k <= 20; k++) begin
      if (!sif.out_busy || sif.out_valid) bad = 1'b1;
      tick();
    end
    sif.in_seed_load = 1'b0;
    chk("unbounded_busy_through_20", int'(bad), 0);
    tick();
    chk("unbounded_not_yet_valid", int'(sif.out_valid), 0);
    tick();
    chk("unbounded_valid_cycle23", int'(sif.out_valid), 1);
    chk("unbounded_value", int'(sif.out_value), 3);
    chk("unbounded_error", int'(sif.out_error), 0);
`endif
    held_value = 3;
    tick();
    load_seed(8'h01);
    model_on = 1'b1;

    // Reset in the middle of a walk.
    model_on = 1'b0;
    sif.in_segment_type = EXPDOWN;
    sif.in_segment_from = 8'sd0;
    sif.in_segment_to   = 8'sd127;
    sif.in_start        = 1'b1;
    tick();
    sif.in_start = 1'b0;
    chk("walk_busy", int'(sif.out_busy), 1);
    chk("walk_state", int'(out_state), int'(WALK));
    #2;
    in_reset_n = 1'b0;
    #1;
    chk("midreset_busy", int'(sif.out_busy), 0);
    chk("midreset_valid", int'(sif.out_valid), 0);
    chk("midreset_value", int'(sif.out_value), 0);
    chk("midreset_error", int'(sif.out_error), 0);
    tick();
    in_reset_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sif.out_valid || sif.out_busy) bad = 1'b1;
      tick();
    end
    chk("no_valid_after_reset", int'(bad), 0);
    model_lfsr = 8'h01;
    held_value = 0;
    model_on   = 1'b1;
    directed("unif_after_reset", 3, 10, 13, 11, 2);

    // Randomized stream.
    prev_b2b = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!prev_b2b && $urandom_range(0, 9) == 0) load_seed(int'($urandom_range(0, 255)));
      t  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      f  = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 2) == 0) begin
        hi = f + int'($urandom_range(0, 6));
        if (hi > 127) hi = 127;
      end else begin
        hi = int'($urandom_range(0, 255)) - 128;
      end
      if (f > hi && $urandom_range(0, 4) != 0) begin
        tmp = f;
        f   = hi;
        hi  = tmp;
      end
      b2b = ($urandom_range(0, 4) == 0);
      issue(t, f, hi, v, l);
      wait_done(l, b2b);
      prev_b2b = b2b;
    end
    if (prev_b2b) tick();

    repeat (3) tick();
    c0 = exp_q.size();
    chk("scoreboard_drained", c0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
